// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg
// Shared definitions for the instruction-memory responder:
//   XLEN_DEFAULT  default address/data width of the responder
//   NOP           instruction word returned for rejected fetches (addi x0,x0,0)
//   rsp_entry_t   one buffered response {data, addr, err}
// The addr field of rsp_entry_t is XLEN_DEFAULT bits wide; a responder built
// with a wider XLEN needs XLEN_DEFAULT raised here as well.
package imem_responder_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0]             data;
    logic [XLEN_DEFAULT-1:0] addr;
    logic                    err;
  } rsp_entry_t;

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo
// Two-entry in-order response buffer, parameterised by entry type.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   push_i        write push_data_i into the tail (ignored when full)
//   push_data_i   entry to store
//   pop_i         drop the head entry (ignored when empty)
//   count_o       number of stored entries (0..2)
//   head_o        oldest stored entry; all-zero after reset
module resp_fifo #(
  parameter type T = logic
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  T           push_data_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output T           head_o
);

  T           slot_q [2];
  T           slot_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // Next-state logic. A simultaneous push and pop moves both pointers and
  // leaves the occupancy unchanged.
  always_comb begin
    slot_d   = slot_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && (count_q != 2'd2);
    if (do_push) begin
      slot_d[wr_ptr_q] = push_data_i;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as all-zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      slot_q    <= slot_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot_q[rd_ptr_q];

endmodule

// File: rtl/imem_responder.sv
// imem_responder
// Instruction memory with a valid/ready fetch port and a program-load port.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   req_valid    fetch request present; req_ready accepts it
//   req_addr     byte address of the requested instruction
//   rsp_valid    response present; rsp_ready consumes it
//   rsp_data     instruction word (NOP on error)
//   rsp_addr     echo of the request address
//   rsp_err      request was misaligned or outside the memory
//   ld_en        program-load strobe writing ld_data to word ld_addr
// Memory contents survive reset; only the response path is cleared.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [XLEN-1:0]          rsp_addr,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [1:0]       fifo_count;
  rsp_entry_t       fifo_head;
  rsp_entry_t       push_entry;
  logic             accept;
  logic             misaligned;
  logic             out_of_range;
  logic [IDX_W-1:0] word_idx;

  // The read is synchronous: the word is sampled straight into a buffer slot
  // on the accepting edge, so the slot doubles as the read-data register and
  // nothing is ever in flight between acceptance and buffering. That makes
  // the buffer occupancy alone decide whether another request fits.
  assign req_ready = (fifo_count != 2'd2);
  assign accept    = req_valid && req_ready;

  // Any address bit at or above log2(4*DEPTH) set means past the end.
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = ((req_addr >> (IDX_W + 2)) != '0);
  assign word_idx     = req_addr[IDX_W+1:2];

  // Build the response entry; a load to the same word on this edge is not
  // yet visible here, so the old word is returned.
  always_comb begin
    push_entry      = '0;
    push_entry.err  = misaligned || out_of_range;
    push_entry.addr = XLEN_DEFAULT'(req_addr);
    push_entry.data = push_entry.err ? NOP : mem_q[word_idx];
  end

  // Program-load port: writes land every cycle it is strobed, unaffected by
  // reset or by the fetch handshake.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  resp_fifo #(
    .T (rsp_entry_t)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_data_i (push_entry),
    .pop_i       (rsp_ready),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_data  = fifo_head.data;
  assign rsp_addr  = XLEN'(fifo_head.addr);
  assign rsp_err   = fifo_head.err;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
// Directed bench for imem_responder (XLEN=32, DEPTH=256). A queue-based
// model predicts every cycle's outputs; the directed sequences also check
// hand-computed literal values.
module tb_imem_responder;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP_WORD = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  int totalChecks = 0;
  int badChecks   = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } expEntry_t;

  expEntry_t   expQ[$];
  logic [31:0] modelMem [DEPTH];

  imem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and report a mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive all inputs for the next clock edge
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic r,
                               input logic le, input logic [7:0] la, input logic [31:0] ld);
    req_valid = v;
    req_addr  = a;
    rsp_ready = r;
    ld_en     = le;
    ld_addr   = la;
    ld_data   = ld;
  endtask

  // What the memory must answer for a byte address
  function automatic expEntry_t predict(input logic [31:0] a);
    expEntry_t e;
    e.addr = a;
    e.err  = (a % 4 != 0) || (a >= 4 * DEPTH);
    e.data = e.err ? NOP_WORD : modelMem[a / 4];
    return e;
  endfunction

  // Model update on each rising edge, then comparison 1 unit later
  initial begin
    expEntry_t newEntry;
    logic popNow, pushNow;
    forever begin
      @(posedge clk);
      if (rst) begin
        expQ.delete();
      end else begin
        popNow  = (expQ.size() > 0) && rsp_ready;
        pushNow = req_valid && (expQ.size() < 2);
        if (pushNow) newEntry = predict(req_addr);
        if (popNow) void'(expQ.pop_front());
        if (pushNow) expQ.push_back(newEntry);
      end
      if (ld_en) modelMem[ld_addr] = ld_data;
      #1;
      checkOutput("req_ready", 64'(req_ready), 64'(expQ.size() < 2));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(expQ.size() > 0));
      if (rst) begin
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("rst_rsp_addr", 64'(rsp_addr), 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
      end else if (expQ.size() > 0) begin
        checkOutput("rsp_data", 64'(rsp_data), 64'(expQ[0].data));
        checkOutput("rsp_addr", 64'(rsp_addr), 64'(expQ[0].addr));
        checkOutput("rsp_err", 64'(rsp_err), 64'(expQ[0].err));
      end
    end
  end

  // Directed sequences with literal expectations, checked at falling edges
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_data", 64'(rsp_data), 64'd0);
    checkOutput("reset_addr", 64'(rsp_addr), 64'd0);
    checkOutput("reset_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;

    // program words 0..3
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 8'(i), 32'((i + 1) * 32'h11));
      @(negedge clk);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    checkOutput("ready_after_reset", 64'(req_ready), 64'd1);

    // back-to-back fetches stream one response per cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 1'b1, 1'b0, 8'h0, 32'h0);
      @(negedge clk);
      checkOutput("stream_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stream_data", 64'(rsp_data), 64'((i + 1) * 32'h11));
      checkOutput("stream_addr", 64'(rsp_addr), 64'(4 * i));
      checkOutput("stream_err", 64'(rsp_err), 64'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    checkOutput("stream_drained", 64'(rsp_valid), 64'd0);

    // consumer stalled: two accepts fill the buffer, the third waits
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    req_addr = 32'h4;
    @(negedge clk);
    req_addr = 32'h8;
    checkOutput("full_ready", 64'(req_ready), 64'd0);
    checkOutput("full_head", 64'(rsp_data), 64'h11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_ready", 64'(req_ready), 64'd0);
      checkOutput("stall_data", 64'(rsp_data), 64'h11);
      checkOutput("stall_addr", 64'(rsp_addr), 64'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("drain_second", 64'(rsp_data), 64'h22);
    checkOutput("drain_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    checkOutput("drain_third", 64'(rsp_data), 64'h33);
    checkOutput("drain_third_addr", 64'(rsp_addr), 64'h8);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("drain_empty", 64'(rsp_valid), 64'd0);

    // misaligned and out-of-range fetches
    applyStimulus(1'b1, 32'h2, 1'b1, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    checkOutput("misalign_err", 64'(rsp_err), 64'd1);
    checkOutput("misalign_data", 64'(rsp_data), 64'h13);
    checkOutput("misalign_addr", 64'(rsp_addr), 64'h2);
    req_addr = 32'h400;
    @(negedge clk);
    checkOutput("range_err", 64'(rsp_err), 64'd1);
    checkOutput("range_data", 64'(rsp_data), 64'h13);
    checkOutput("range_addr", 64'(rsp_addr), 64'h400);
    req_addr = 32'h3FC;
    @(negedge clk);
    checkOutput("last_word_err", 64'(rsp_err), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);

    // load and fetch of the same word on the same edge
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b1, 8'h1, 32'hAA);
    @(negedge clk);
    checkOutput("same_cycle_old", 64'(rsp_data), 64'h22);
    ld_en = 1'b0;
    @(negedge clk);
    checkOutput("next_cycle_new", 64'(rsp_data), 64'hAA);
    req_valid = 1'b0;
    @(negedge clk);

    // reset with two pending responses
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    req_addr = 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("pre_reset_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_valid", 64'(rsp_valid), 64'd0);
    checkOutput("async_reset_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_reset_valid", 64'(rsp_valid), 64'd0);
      checkOutput("post_reset_ready", 64'(req_ready), 64'd1);
    end
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    checkOutput("mem_kept_w0", 64'(rsp_data), 64'h11);
    req_addr = 32'h8;
    @(negedge clk);
    checkOutput("mem_kept_w2", 64'(rsp_data), 64'h33);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
